// File: rtl/ingress_queue.sv
// ingress_queue: per-port ingress FIFO for the 4-port switch.
// Packs {data, target, source} into one word, drops malformed packets,
// and presents the head packet plus its one-hot request to the arbiter.

package packet_pkg;
    localparam int DATA_WIDTH   = 8;
    localparam int ADDR_WIDTH   = 4;
    localparam int PACKET_WIDTH = DATA_WIDTH + 2 * ADDR_WIDTH;
endpackage

module ingress_queue
    import packet_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            valid_in,
    input  logic [DATA_WIDTH-1:0]           data_in,
    input  logic [ADDR_WIDTH-1:0]           target_in,
    input  logic [ADDR_WIDTH-1:0]           source_in,
    output logic                            ready_out,
    output logic [PACKET_WIDTH-1:0]         pkt_out,
    output logic                            pkt_valid,
    output logic [ADDR_WIDTH-1:0]           req_out,
    input  logic                            grant_in,
    output logic [$clog2(FIFO_DEPTH):0]     occupancy,
    output logic [7:0]                      drop_cnt
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int OW = PW + 1;
    localparam logic [OW-1:0] FULL_COUNT = OW'(FIFO_DEPTH);

    // Packet storage; deliberately not reset, empty-gating hides stale data.
    logic [PACKET_WIDTH-1:0] mem_q [FIFO_DEPTH];

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [OW-1:0] occ_q, occ_d;
    logic [7:0]    drop_q, drop_d;

    logic full, empty, well_formed, push, pop, drop_evt;
    logic [PACKET_WIDTH-1:0] pkt_in;

    assign pkt_in = {data_in, target_in, source_in};
    assign full   = (occ_q == FULL_COUNT);
    assign empty  = (occ_q == '0);

    // Exactly one bit set in each address and no loopback to the sender.
    assign well_formed = (target_in != '0)
                      && ((target_in & (target_in - 1'b1)) == '0)
                      && (source_in != '0)
                      && ((source_in & (source_in - 1'b1)) == '0)
                      && (target_in != source_in);

    // ready_out is forced low during reset so nothing is pushed on a reset edge.
    assign ready_out = ~rst & ~full;
    assign push      = valid_in & ready_out & well_formed;
    assign drop_evt  = valid_in & ready_out & ~well_formed;
    assign pop       = grant_in & ~empty;

    // Head presentation: zero when empty so no X reaches the output mux.
    assign pkt_valid = ~empty;
    assign pkt_out   = empty ? '0 : mem_q[rd_ptr_q];
    assign req_out   = pkt_out[2*ADDR_WIDTH-1:ADDR_WIDTH];
    assign occupancy = occ_q;
    assign drop_cnt  = drop_q;

    // Next-state for pointers, occupancy and the saturating drop counter.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        occ_d    = occ_q;
        drop_d   = drop_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        if (push && !pop) begin
            occ_d = occ_q + OW'(1);
        end else if (pop && !push) begin
            occ_d = occ_q - OW'(1);
        end
        if (drop_evt && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
        end
    end

    // Control registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            occ_q    <= '0;
            drop_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            occ_q    <= occ_d;
            drop_q   <= drop_d;
        end
    end

    // Per-entry write enables decoded from the write pointer.
    for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q == PW'(gi))) begin
                mem_q[gi] <= pkt_in;
            end
        end
    end

endmodule
